// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
package pipeline_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter for performance monitoring; holds at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}}))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) count_q <= '0;
        else         count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: combinational register
// enables/clears from state and hazards, plus stall and flush counters.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic [4:0]       rd_ex,
    input  logic             mem_read_ex,
    input  logic             branch_taken_ex,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_e state_q, state_d;
    logic   mem_stall, load_use, fetch_stall, hold, flush_inc, stall_inc;

    assign mem_stall   = dmem_req & ~dmem_ready;
    assign load_use    = mem_read_ex & (rd_ex != REG_ZERO) &
                         ((rd_ex == rs1_id) | (rd_ex == rs2_id));
    assign fetch_stall = ~imem_ready;

    // In MEM_WAIT only dmem_ready releases the freeze; EX is held so a
    // pending branch is re-evaluated on the release cycle.
    assign hold = (state_q == MEM_WAIT) ? ~dmem_ready : mem_stall;

    always_comb begin
        state_d     = state_q;
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_en    = 1'b0;
        ex_mem_en   = 1'b0;
        mem_wb_en   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        flush_inc   = 1'b0;
        case (state_q)
            RUN, MEM_WAIT: begin
                if (hold) begin
                    state_d = MEM_WAIT;
                end else begin
                    state_d   = RUN;
                    pc_en     = 1'b1;
                    if_id_en  = 1'b1;
                    id_ex_en  = 1'b1;
                    ex_mem_en = 1'b1;
                    mem_wb_en = 1'b1;
                    if (branch_taken_ex) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        flush_inc   = 1'b1;
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end else if (fetch_stall) begin
                        pc_en       = 1'b0;
                        if_id_flush = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = RUN;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end
        endcase
    end

    assign stall_inc = (state_q != BOOT) & ~pc_en;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state_q <= BOOT;
        else         state_q <= state_d;
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk(clk), .arst_n(arst_n), .inc(stall_inc), .count(stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk(clk), .arst_n(arst_n), .inc(flush_inc), .count(flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed table-driven bench for pipeline_ctrl, plus multi-cycle sequences.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       arst_n;
    logic [4:0] rs1_id, rs2_id, rd_ex;
    logic       mem_read_ex, branch_taken_ex, imem_ready, dmem_req, dmem_ready;

    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;
    logic [31:0] stall_cnt, flush_cnt;
    logic        pc_en4, if_id_en4, id_ex_en4, ex_mem_en4, mem_wb_en4, if_id_flush4, id_ex_flush4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk(clk), .arst_n(arst_n), .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_ex(rd_ex),
        .mem_read_ex(mem_read_ex), .branch_taken_ex(branch_taken_ex),
        .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .arst_n(arst_n), .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_ex(rd_ex),
        .mem_read_ex(mem_read_ex), .branch_taken_ex(branch_taken_ex),
        .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en4), .if_id_en(if_id_en4), .id_ex_en(id_ex_en4), .ex_mem_en(ex_mem_en4),
        .mem_wb_en(mem_wb_en4), .if_id_flush(if_id_flush4), .id_ex_flush(id_ex_flush4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
    localparam logic [6:0] O_BOOT  = 7'b0000011;
    localparam logic [6:0] O_RUN   = 7'b1111100;
    localparam logic [6:0] O_FRZ   = 7'b0000000;
    localparam logic [6:0] O_LU    = 7'b0011101;
    localparam logic [6:0] O_FETCH = 7'b0111110;
    localparam logic [6:0] O_BR    = 7'b1111111;

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       mr, br, im, dq, dr;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[11];
    int   n_pass = 0, n_tot = 0;
    int   exp_stall, exp_flush;

    function automatic logic [6:0] outs();
        return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input logic [4:0] a, b, c, input logic mr, br, im, dq, dr);
        rs1_id = a; rs2_id = b; rd_ex = c;
        mem_read_ex = mr; branch_taken_ex = br; imem_ready = im;
        dmem_req = dq; dmem_ready = dr;
    endtask

    task automatic idle();
        drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // Inputs are driven just after posedge; outputs sampled at negedge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reset, release mid-cycle, then step into RUN.
    task automatic do_reset();
        idle();
        arst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        next_cycle();
    endtask

    initial begin
        idle();
        arst_n = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset_outs", 32'(outs()), 32'(O_BOOT));
        chk("reset_stall_cnt", stall_cnt, 32'd0);
        chk("reset_flush_cnt", flush_cnt, 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        #1;
        chk("boot_after_release", 32'(outs()), 32'(O_BOOT));
        next_cycle();
        @(negedge clk);
        chk("first_run_outs", 32'(outs()), 32'(O_RUN));
        chk("first_run_stall_cnt", stall_cnt, 32'd0);
        chk("first_run_flush_cnt", flush_cnt, 32'd0);
        next_cycle();

        // Single-cycle decision table, all from RUN
        tbl[0]  = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_RUN};
        tbl[1]  = '{5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, O_LU};
        tbl[2]  = '{5'd1, 5'd7, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, O_LU};
        tbl[3]  = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, O_RUN};
        tbl[4]  = '{5'd5, 5'd2, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_RUN};
        tbl[5]  = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_FETCH};
        tbl[6]  = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, O_BR};
        tbl[7]  = '{5'd5, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_BR};
        tbl[8]  = '{5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_LU};
        tbl[9]  = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, O_RUN};
        tbl[10] = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, O_RUN};
        exp_stall = 0;
        exp_flush = 0;
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].mr, tbl[i].br,
                  tbl[i].im, tbl[i].dq, tbl[i].dr);
            @(negedge clk);
            chk($sformatf("tbl[%0d]", i), 32'(outs()), 32'(tbl[i].exp));
            if (!tbl[i].exp[6]) exp_stall++;
            if (tbl[i].br)      exp_flush++;
            next_cycle();
        end
        chk("tbl_stall_cnt", stall_cnt, 32'(exp_stall));
        chk("tbl_flush_cnt", flush_cnt, 32'(exp_flush));

        // Load-use bubble lasts one cycle; x0 never stalls
        do_reset();
        drive(5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("lu_bubble", 32'(outs()), 32'(O_LU));
        next_cycle();
        idle();
        @(negedge clk);
        chk("lu_after", 32'(outs()), 32'(O_RUN));
        next_cycle();
        chk("lu_stall_cnt", stall_cnt, 32'd1);
        drive(5'd0, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("lu_x0", 32'(outs()), 32'(O_RUN));
        next_cycle();
        chk("lu_x0_stall_cnt", stall_cnt, 32'd1);

        // Memory wait 3 cycles with a branch pending; branch applied on release
        do_reset();
        drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("mw_c1", 32'(outs()), 32'(O_FRZ));
        next_cycle();
        @(negedge clk);
        chk("mw_c2", 32'(outs()), 32'(O_FRZ));
        next_cycle();
        dmem_req = 1'b0;
        @(negedge clk);
        chk("mw_c3_hold", 32'(outs()), 32'(O_FRZ));
        next_cycle();
        chk("mw_flush_held", flush_cnt, 32'd0);
        dmem_req = 1'b1;
        dmem_ready = 1'b1;
        @(negedge clk);
        chk("mw_release_br", 32'(outs()), 32'(O_BR));
        next_cycle();
        idle();
        @(negedge clk);
        chk("mw_back_run", 32'(outs()), 32'(O_RUN));
        chk("mw_stall_cnt", stall_cnt, 32'd3);
        chk("mw_flush_cnt", flush_cnt, 32'd1);
        next_cycle();

        // Release from MEM_WAIT into a load-use bubble still counts as stall
        do_reset();
        drive(5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("mwlu_frz", 32'(outs()), 32'(O_FRZ));
        next_cycle();
        dmem_ready = 1'b1;
        @(negedge clk);
        chk("mwlu_release", 32'(outs()), 32'(O_LU));
        next_cycle();
        chk("mwlu_stall_cnt", stall_cnt, 32'd2);

        // Fetch stall for two cycles
        do_reset();
        drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("fs_c1", 32'(outs()), 32'(O_FETCH));
        next_cycle();
        @(negedge clk);
        chk("fs_c2", 32'(outs()), 32'(O_FETCH));
        next_cycle();
        chk("fs_stall_cnt", stall_cnt, 32'd2);

        // Saturation: 20 stalls and 17 flushes
        do_reset();
        drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) next_cycle();
        chk("sat_stall4", 32'(stall_cnt4), 32'd15);
        chk("sat_stall32", stall_cnt, 32'd20);
        drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) next_cycle();
        chk("sat_flush4", 32'(flush_cnt4), 32'd15);
        chk("sat_flush32", flush_cnt, 32'd17);
        chk("sat_stall4_hold", 32'(stall_cnt4), 32'd15);

        // Reset asserted mid-MEM_WAIT
        do_reset();
        drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        next_cycle();
        next_cycle();
        #2;
        arst_n = 1'b0;
        #1;
        chk("rst_mw_outs", 32'(outs()), 32'(O_BOOT));
        chk("rst_mw_stall_cnt", stall_cnt, 32'd0);
        @(negedge clk);
        idle();
        arst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("rst_mw_run", 32'(outs()), 32'(O_RUN));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected done");
        $fatal(1);
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It decides, every cycle, which pipeline registers advance, which are bubbled, and when the front end is redirected. It covers load-use hazards not solvable by forwarding, taken-branch/jump flushes, and variable-latency instruction/data memory handshakes. It sits beside the forwarding logic, drives the write-enables and clears of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and keeps saturating stall and flush counters for performance monitoring.

## Interface
- CNT_W, 32, width of performance counters
- clk  in  1  system clock
- arst_n  in  1  asynchronous active-low reset
- rs1_id  in  5  source register 1 of instruction in ID
- rs2_id  in  5  source register 2 of instruction in ID
- rd_ex  in  5  destination register of instruction in EX
- mem_read_ex  in  1  instruction in EX is a load
- branch_taken_ex  in  1  branch/jump resolved taken in EX
- imem_ready  in  1  instruction fetch data valid this cycle
- dmem_req  in  1  MEM stage is issuing a load/store
- dmem_ready  in  1  data memory completes access this cycle
- pc_en  out  1  PC register update enable
- if_id_en / id_ex_en / ex_mem_en / mem_wb_en  out  1 each  pipeline register enables
- if_id_flush  out  1  clear IF/ID to NOP (synchronous, takes effect at next edge)
- id_ex_flush  out  1  clear ID/EX to bubble
- stall_cnt  out  CNT_W  cycles with pc_en=0
- flush_cnt  out  CNT_W  taken-branch flush events

## Operation
- States: BOOT, RUN, MEM_WAIT. arst_n low forces BOOT; BOOT → RUN on first clock after release.
- BOOT outputs: all enables 0, both flushes 1.
- Hazard terms (RUN only):
  - mem_stall = dmem_req & !dmem_ready
  - load_use = mem_read_ex & rd_ex != 0 & (rd_ex == rs1_id | rd_ex == rs2_id)
  - fetch_stall = !imem_ready
- Priority in RUN, highest first:
  1. mem_stall: all enables 0, no flush; next state MEM_WAIT.
  2. branch_taken_ex: all enables 1, if_id_flush=1, id_ex_flush=1; flush_cnt += 1. Overrides load_use and fetch_stall (wrong-path instructions discarded).
  3. load_use: pc_en=0, if_id_en=0, id_ex_en=1 with id_ex_flush=1, ex_mem_en=1, mem_wb_en=1.
  4. fetch_stall: pc_en=0, if_id_en=1 with if_id_flush=1, rest 1.
  5. else: all enables 1, no flush.
- MEM_WAIT: all enables 0, no flush, while dmem_ready=0. When dmem_ready=1, apply RUN priority rules 2–5 the same cycle with mem_stall treated as 0; next state RUN.
- stall_cnt increments every cycle pc_en=0, excluding BOOT. Both counters saturate at all-ones; never wrap.
- rd_ex == x0 never causes load_use.

## Timing
- All control outputs are combinational from state and inputs; zero-cycle latency. Counters and state are registered.
- Reset values: state BOOT, stall_cnt 0, flush_cnt 0; outputs per BOOT while arst_n low.
- Reset mid-MEM_WAIT: immediate return to BOOT; the outstanding memory access is abandoned.
- Load-use bubble lasts exactly one cycle: the next cycle the load is in MEM and forwarding resolves the dependency.
- dmem_ready asserted in the same cycle as dmem_req: no stall, state stays RUN.
- Branch and mem_stall in the same cycle: freeze wins; the branch is re-evaluated when the pipeline releases, because EX is held.

## Structure
- Shared package `pipeline_pkg`: state enum (BOOT, RUN, MEM_WAIT), REG_ZERO = 5'd0.
- Sub-module `sat_counter` (parameter W; inc, count), instantiated twice.
- The hazard terms are local combinational logic; there is no further decomposition.

## Test plan
- Reset release: all enables 0 and flushes 1 during reset; the cycle after release, all enables 1 and counters 0.
- Load x5 in EX, ID reads rs1=x5: one cycle with pc_en=0 and id_ex_flush=1, then all 1; stall_cnt = 1. Repeat with rd_ex = x0: no stall.
- dmem_req=1, dmem_ready low for 3 cycles: 3 cycles all enables 0, state MEM_WAIT; release on the 4th; stall_cnt = 3.
- branch_taken_ex with load_use and imem_ready=0 simultaneously: both flushes 1, pc_en=1; flush_cnt = 1.
- imem_ready=0 for 2 cycles: pc_en=0 and if_id_flush=1 for both cycles, downstream enables 1.
- CNT_W=4, 20 forced stall cycles: stall_cnt holds at 15. Assert arst_n low mid-MEM_WAIT: state BOOT immediately.
